// File: rtl/max_pool_2x2_stream_if.sv
// Pixel stream bundle for the 2x2 max-pool stage.
// The producer side drives In/Valid_IN; the pool stage drives the pooled result.
interface max_pool_2x2_stream_if #(
  parameter int Datawidth = 32
);
  logic [Datawidth-1:0] In;
  logic                 Valid_IN;
  logic [Datawidth-1:0] Out;
  logic                 Valid_OUT;
  logic                 Frame_Done;

  modport master (
    output In, Valid_IN,
    input  Out, Valid_OUT, Frame_Done
  );

  modport slave (
    input  In, Valid_IN,
    output Out, Valid_OUT, Frame_Done
  );
endinterface

// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2 / stride-2 max pooling over a raster-order pixel stream.
// Keeps one half-width row of partial maxima plus a single running temp.
module max_pool_2x2_stream #(
  parameter int IMG_Width  = 4,
  parameter int IMG_Height = 4,
  parameter int Datawidth  = 32,
  parameter bit Signed     = 1'b1
) (
  input logic CLK,
  input logic CLR,
  max_pool_2x2_stream_if.slave s
);
  localparam int PW = IMG_Width / 2;
  localparam int PH = IMG_Height / 2;
  localparam int CW = (IMG_Width > 2) ? $clog2(IMG_Width) : 1;
  localparam int RW = (IMG_Height > 2) ? $clog2(IMG_Height) : 1;
  localparam int IW = (PW > 1) ? $clog2(PW) : 1;

  typedef logic [Datawidth-1:0] pix_t;

  function automatic pix_t f_max(input pix_t a, input pix_t b);
    logic w_gt;
    w_gt = Signed ? ($signed(a) > $signed(b)) : (a > b);
    return w_gt ? a : b;
  endfunction

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  pix_t          r_temp;
  pix_t          r_out;
  pix_t          r_buf [PW];
  logic          r_vo;
  logic          r_fd;

  logic          w_col_last;
  logic          w_row_last;
  logic          w_pool;
  logic          w_last_win;
  logic [IW-1:0] w_idx;
  pix_t          w_lhs;
  pix_t          w_max;

  assign w_col_last = (r_col == CW'(IMG_Width - 1));
  assign w_row_last = (r_row == RW'(IMG_Height - 1));
  assign w_pool     = (int'(r_col) < 2 * PW) &&
                      (int'(r_row) < 2 * PH);
  assign w_last_win = (r_col == CW'(2 * PW - 1)) &&
                      (r_row == RW'(2 * PH - 1));
  assign w_idx      = IW'(r_col >> 1);
  // Odd column pairs with temp; even column of an odd row pulls the top-row max.
  assign w_lhs      = r_col[0] ? r_temp : r_buf[w_idx];
  assign w_max      = f_max(w_lhs, s.In);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_col  <= '0;
      r_row  <= '0;
      r_temp <= '0;
      r_out  <= '0;
      r_vo   <= 1'b0;
      r_fd   <= 1'b0;
      for (int i = 0; i < PW; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_vo <= 1'b0;
      r_fd <= 1'b0;
      if (s.Valid_IN) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_pool) begin
          unique case ({r_row[0], r_col[0]})
            2'b00: r_temp <= s.In;
            2'b01: r_buf[w_idx] <= w_max;
            2'b10: r_temp <= w_max;
            2'b11: begin
              r_out <= w_max;
              r_vo  <= 1'b1;
              r_fd  <= w_last_win;
            end
          endcase
        end
      end
    end
  end

  assign s.Out        = r_out;
  assign s.Valid_OUT  = r_vo;
  assign s.Frame_Done = r_fd;
endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Bench for max_pool_2x2_stream: image-level model plus literal result lists.
// Three instances cover signed 4x4, unsigned 4x4 and signed 5x5.
module tb_max_pool_2x2_stream;
  logic CLK = 1'b0;
  logic CLR;
  always #5 CLK = ~CLK;

  max_pool_2x2_stream_if #(.Datawidth(32)) if0 ();
  max_pool_2x2_stream_if #(.Datawidth(32)) if1 ();
  max_pool_2x2_stream_if #(.Datawidth(32)) if2 ();

  max_pool_2x2_stream #(
    .IMG_Width(4), .IMG_Height(4), .Datawidth(32), .Signed(1'b1)
  ) u0 (.CLK(CLK), .CLR(CLR), .s(if0.slave));
  max_pool_2x2_stream #(
    .IMG_Width(4), .IMG_Height(4), .Datawidth(32), .Signed(1'b0)
  ) u1 (.CLK(CLK), .CLR(CLR), .s(if1.slave));
  max_pool_2x2_stream #(
    .IMG_Width(5), .IMG_Height(5), .Datawidth(32), .Signed(1'b1)
  ) u2 (.CLK(CLK), .CLR(CLR), .s(if2.slave));

  typedef struct {
    logic [31:0] v;
    logic        fd;
    int          due;
  } exp_t;

  exp_t        q   [3][$];
  logic [31:0] obs [3][$];
  int          fdcnt [3];
  logic [31:0] last  [3];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          W [3] = '{4, 4, 5};
  int          H [3] = '{4, 4, 5};
  bit          S [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] img [3][5][5];
  int          pos [3];

  logic        vin [3];
  logic        vo  [3];
  logic        fdo [3];
  logic [31:0] din  [3];
  logic [31:0] dout [3];

  assign vin[0] = if0.Valid_IN;  assign din[0] = if0.In;
  assign vin[1] = if1.Valid_IN;  assign din[1] = if1.In;
  assign vin[2] = if2.Valid_IN;  assign din[2] = if2.In;
  assign vo[0] = if0.Valid_OUT;  assign dout[0] = if0.Out;
  assign vo[1] = if1.Valid_OUT;  assign dout[1] = if1.Out;
  assign vo[2] = if2.Valid_OUT;  assign dout[2] = if2.Out;
  assign fdo[0] = if0.Frame_Done;
  assign fdo[1] = if1.Frame_Done;
  assign fdo[2] = if2.Frame_Done;

  function automatic logic [31:0] mx(
    input bit sg, input logic [31:0] a, input logic [31:0] b);
    if (sg) return ($signed(a) > $signed(b)) ? a : b;
    return (a > b) ? a : b;
  endfunction

  // Model: store the image, emit a window max when its bottom-right pixel lands.
  int mr, mc, mpw, mph;
  logic [31:0] mm;
  always @(posedge CLK) begin
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (!CLR) begin
        pos[d] = 0;
      end else if (vin[d]) begin
        mr  = pos[d] / W[d];
        mc  = pos[d] % W[d];
        mpw = W[d] / 2;
        mph = H[d] / 2;
        img[d][mr][mc] = din[d];
        if ((mr % 2 == 1) && (mc % 2 == 1) &&
            (mr < 2 * mph) && (mc < 2 * mpw)) begin
          mm = mx(S[d], img[d][mr-1][mc-1], img[d][mr-1][mc]);
          mm = mx(S[d], mm, img[d][mr][mc-1]);
          mm = mx(S[d], mm, img[d][mr][mc]);
          q[d].push_back('{v: mm,
            fd: (mr == 2*mph-1) && (mc == 2*mpw-1), due: cyc});
        end
        pos[d] = (pos[d] + 1) % (W[d] * H[d]);
      end
    end
  end

  exp_t ce;
  always @(negedge CLK) begin
    for (int d = 0; d < 3; d++) begin
      if (!CLR) begin
        q[d].delete();
        last[d] = '0;
      end else if (vo[d]) begin
        n_tests++;
        if (q[d].size() == 0) begin
          n_fail++;
          $display("FAIL spurious d%0d: Out=%h with no window due",
                   d, dout[d]);
        end else begin
          ce = q[d].pop_front();
          if (dout[d] !== ce.v || fdo[d] !== ce.fd || ce.due != cyc) begin
            n_fail++;
            $display("FAIL strobe d%0d: Out=%h fd=%b cyc=%0d, need %h fd=%b cyc=%0d",
                     d, dout[d], fdo[d], cyc, ce.v, ce.fd, ce.due);
          end
        end
        obs[d].push_back(dout[d]);
        last[d] = dout[d];
        if (fdo[d]) fdcnt[d]++;
      end else begin
        n_tests++;
        if (fdo[d] !== 1'b0 || dout[d] !== last[d]) begin
          n_fail++;
          $display("FAIL idle d%0d: Out=%h fd=%b, need Out=%h fd=0",
                   d, dout[d], fdo[d], last[d]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, need %h", nm, act, exp);
    end
  endtask

  task automatic chk_obs(input int d, input string nm,
                         input logic [31:0] e[$]);
    n_tests++;
    if (obs[d].size() != e.size()) begin
      n_fail++;
      $display("FAIL %s count: got %0d outputs, need %0d",
               nm, obs[d].size(), e.size());
    end else begin
      foreach (e[i]) chk(nm, obs[d][i], e[i]);
    end
    obs[d].delete();
  endtask

  task automatic endchk(input string nm);
    for (int d = 0; d < 3; d++)
      chk(nm, q[d].size(), 0);
  endtask

  task automatic put(input logic [2:0] m, input logic [31:0] v);
    @(posedge CLK);
    #1;
    if0.Valid_IN = m[0];  if0.In = v;
    if1.Valid_IN = m[1];  if1.In = v;
    if2.Valid_IN = m[2];  if2.In = v;
  endtask

  task automatic idle(input int n);
    repeat (n) put(3'b000, '0);
  endtask

  task automatic frame(input logic [2:0] m, input int base,
                       input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      put(m, 32'(base + k));
      idle(gap);
    end
  endtask

  logic [31:0] e [$];
  int          f0;

  initial begin
    CLR = 1'b0;
    if0.Valid_IN = 0;  if0.In = '0;
    if1.Valid_IN = 0;  if1.In = '0;
    if2.Valid_IN = 0;  if2.In = '0;
    for (int d = 0; d < 3; d++) begin
      fdcnt[d] = 0;
      last[d]  = '0;
      pos[d]   = 0;
    end
    repeat (2) @(posedge CLK);
    #1;
    chk("rst out0", dout[0], 0);
    chk("rst vo0", 32'(vo[0]), 0);
    chk("rst fd0", 32'(fdo[0]), 0);
    chk("rst out2", dout[2], 0);
    CLR = 1'b1;
    idle(2);

    frame(3'b001, 1, 16, 0);
    idle(3);
    e = '{32'd6, 32'd8, 32'd14, 32'd16};
    chk_obs(0, "ramp", e);
    chk("ramp fd", fdcnt[0], 1);
    endchk("ramp left");

    for (int k = 0; k < 16; k++)
      put(3'b011, (k == 5) ? 32'hFFFFFFFF : 32'hFFFFFFF0);
    idle(3);
    e = '{32'hFFFFFFFF, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0};
    chk_obs(0, "neg s", e);
    chk_obs(1, "neg u", e);

    for (int k = 0; k < 16; k++)
      put(3'b011, (k == 0) ? 32'd1 :
        (k == 1 || k == 4 || k == 5) ? 32'hFFFFFFFF : 32'd0);
    idle(3);
    e = '{32'd1, 32'd0, 32'd0, 32'd0};
    chk_obs(0, "sign s", e);
    e = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
    chk_obs(1, "sign u", e);
    endchk("sign left");

    frame(3'b001, 1, 16, 3);
    idle(3);
    e = '{32'd6, 32'd8, 32'd14, 32'd16};
    chk_obs(0, "gaps", e);

    frame(3'b100, 1, 50, 0);
    idle(3);
    e = '{32'd7, 32'd9, 32'd17, 32'd19,
          32'd32, 32'd34, 32'd42, 32'd44};
    chk_obs(2, "5x5", e);
    chk("5x5 fd", fdcnt[2], 2);
    endchk("5x5 left");

    frame(3'b001, 1, 6, 0);
    put(3'b000, '0);
    chk("pre-rst vo", 32'(vo[0]), 1);
    #1 CLR = 1'b0;
    #1;
    chk("rst vo", 32'(vo[0]), 0);
    chk("rst out", dout[0], 0);
    idle(2);
    CLR = 1'b1;
    obs[0].delete();
    frame(3'b001, 1, 16, 0);
    idle(3);
    e = '{32'd6, 32'd8, 32'd14, 32'd16};
    chk_obs(0, "post-rst", e);

    f0 = fdcnt[0];
    frame(3'b001, 1, 16, 0);
    frame(3'b001, 101, 16, 0);
    idle(3);
    e = '{32'd6, 32'd8, 32'd14, 32'd16,
          32'd106, 32'd108, 32'd114, 32'd116};
    chk_obs(0, "b2b", e);
    chk("b2b fd", fdcnt[0] - f0, 2);
    endchk("b2b left");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
